// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default sizes for the memory-port arbiter.
//   arb_state_e  : sequencer states IDLE -> ADDR -> DATA
//   DEF_*        : default requester count, address width and data width
//   idx_w()      : width of a requester index / round-robin pointer
// Configuration macro used by the arbiter files: MEM_ARB_FIXED_PRIO_EN
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;

  // Index width for NUM_REQ requesters; never less than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational request picker. Scans the request vector starting at the
// round-robin pointer (wrapping) and returns the first active requester.
// With MEM_ARB_FIXED_PRIO_EN defined the scan always starts at index 0
// (lowest index wins) and the pointer port does not exist.
// Ports:
//   i_req   [NUM_REQ]  request vector
//   i_ptr   [PTR_W]    index where the search starts (round-robin build only)
//   o_gnt   [NUM_REQ]  one-hot winner, zero when no request
//   o_idx   [PTR_W]    binary index of the winner
//   o_valid            at least one request present
// ----------------------------------------------------------------------------
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
`ifndef MEM_ARB_FIXED_PRIO_EN
  input  logic [PTR_W-1:0]   i_ptr,
`endif
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_valid
);

  always_comb begin
    int k;
    // NOTE: every output gets a default before the search loop so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    k       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      k = i;
`else
      k = (int'(i_ptr) + i) % NUM_REQ;
`endif
      if (!o_valid && i_req[k]) begin
        o_valid  = 1'b1;
        o_idx    = PTR_W'(k);
        o_gnt[k] = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares one synchronous-read memory port (1-cycle read latency) between
// NUM_REQ requesters. Each access runs IDLE/DATA -> ADDR -> DATA: the winner
// is registered, its fields drive the memory for one ADDR cycle (gnt_o pulse),
// and in the following DATA cycle rvalid_o pulses with the read data.
// Arbitration is round-robin by default; defining MEM_ARB_FIXED_PRIO_EN
// selects fixed priority (lowest index wins) and removes the pointer.
// Ports:
//   clk, reset_i          clock, synchronous active-high reset
//   req_i/we_i            per-requester request and write flag
//   addr_i/wr_mask_i/
//   wdata_i               packed per-requester fields (req k at slice k)
//   gnt_o                 one-hot pulse, address phase accepted
//   rvalid_o, rdata_o     one-hot completion pulse, read data (0 for writes)
//   mem_addr_o, mem_we_o,
//   mem_wr_mask_o,
//   mem_data_out_o        memory command, non-zero only in ADDR
//   mem_data_in_i         memory read data, valid the cycle after the address
// ----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr_i,
  input  logic [NUM_REQ*DATA_W/8-1:0] wr_mask_i,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         rvalid_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic                       mem_we_o,
  output logic [DATA_W/8-1:0]        mem_wr_mask_o,
  output logic [DATA_W-1:0]          mem_data_out_o,
  input  logic [DATA_W-1:0]          mem_data_in_i
);

  localparam int PTR_W  = idx_w(NUM_REQ);
  localparam int MASK_W = DATA_W / 8;

  arb_state_e          r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_rvalid;
  logic                r_win_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_we;
  logic [MASK_W-1:0]   r_mem_mask;
  logic [DATA_W-1:0]   r_mem_data;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0]    r_ptr;
`endif

  logic [NUM_REQ-1:0]  w_pick_gnt;
  logic [PTR_W-1:0]    w_pick_idx;
  logic                w_pick_valid;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [MASK_W-1:0]   w_sel_mask;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_sel_we;

  // A requester whose req is still high in its own DATA cycle is simply
  // picked again: the access it just finished is no longer outstanding.
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .i_req   (req_i),
`ifndef MEM_ARB_FIXED_PRIO_EN
    .i_ptr   (r_ptr),
`endif
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Fields of the requester being picked this cycle.
  assign w_sel_addr = addr_i[int'(w_pick_idx)*ADDR_W +: ADDR_W];
  assign w_sel_mask = wr_mask_i[int'(w_pick_idx)*MASK_W +: MASK_W];
  assign w_sel_data = wdata_i[int'(w_pick_idx)*DATA_W +: DATA_W];
  assign w_sel_we   = we_i[w_pick_idx];

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_rvalid   <= '0;
      r_win_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_we   <= 1'b0;
      r_mem_mask <= '0;
      r_mem_data <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_ptr      <= '0;
`endif
    end else begin
      r_rvalid <= '0;
      case (r_state)
        // IDLE and DATA both launch the next access when anything is pending.
        IDLE, DATA: begin
          if (w_pick_valid) begin
            r_state    <= ADDR;
            r_gnt      <= w_pick_gnt;
            r_win_we   <= w_sel_we;
            r_mem_addr <= w_sel_addr;
            r_mem_we   <= w_sel_we;
            // Mask and write data are only meaningful for writes.
            r_mem_mask <= w_sel_we ? w_sel_mask : '0;
            r_mem_data <= w_sel_we ? w_sel_data : '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            r_ptr      <= (w_pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        ADDR: begin
          r_state    <= DATA;
          r_gnt      <= '0;
          r_rvalid   <= r_gnt;
          r_mem_addr <= '0;
          r_mem_we   <= 1'b0;
          r_mem_mask <= '0;
          r_mem_data <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign gnt_o          = r_gnt;
  assign rvalid_o       = r_rvalid;
  assign mem_addr_o     = r_mem_addr;
  assign mem_we_o       = r_mem_we;
  assign mem_wr_mask_o  = r_mem_mask;
  assign mem_data_out_o = r_mem_data;

  // Memory data arrives during DATA, so it is forwarded straight through;
  // registering it would push rvalid one cycle later than the address phase
  // allows. Writes and idle cycles return zero.
  assign rdata_o = ((|r_rvalid) && !r_win_we) ? mem_data_in_i : '0;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a 16-word behavioural memory
// (word index = addr[5:2], one-cycle registered read, byte-masked writes).
// Expected grant order for simultaneous requesters follows the build:
// MEM_ARB_FIXED_PRIO_EN defined -> requester 0 always wins.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MASK_W  = DATA_W / 8;

  logic                        clk;
  logic                        reset_i;
  logic [NUM_REQ-1:0]          req_i;
  logic [NUM_REQ-1:0]          we_i;
  logic [NUM_REQ*ADDR_W-1:0]   addr_i;
  logic [NUM_REQ*MASK_W-1:0]   wr_mask_i;
  logic [NUM_REQ*DATA_W-1:0]   wdata_i;
  logic [NUM_REQ-1:0]          gnt_o;
  logic [NUM_REQ-1:0]          rvalid_o;
  logic [DATA_W-1:0]           rdata_o;
  logic [ADDR_W-1:0]           mem_addr_o;
  logic                        mem_we_o;
  logic [MASK_W-1:0]           mem_wr_mask_o;
  logic [DATA_W-1:0]           mem_data_out_o;
  logic [DATA_W-1:0]           mem_data_in_i;

  int n_cmp = 0;
  int n_mis = 0;

  mem_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .req_i          (req_i),
    .we_i           (we_i),
    .addr_i         (addr_i),
    .wr_mask_i      (wr_mask_i),
    .wdata_i        (wdata_i),
    .gnt_o          (gnt_o),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_wr_mask_o  (mem_wr_mask_o),
    .mem_data_out_o (mem_data_out_o),
    .mem_data_in_i  (mem_data_in_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory; preload only while tb_preload is set.
  logic [31:0] tb_mem [16];
  logic        tb_preload;

  always @(posedge clk) begin
    if (tb_preload) begin
      for (int w = 0; w < 16; w++) tb_mem[w] <= 32'h0;
      tb_mem[4] <= 32'hDEAD_BEEF;
      tb_mem[8] <= 32'hAAAA_AAAA;
    end else if (mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_wr_mask_o[b]) tb_mem[mem_addr_o[5:2]][8*b +: 8] <= mem_data_out_o[8*b +: 8];
    end
    mem_data_in_i <= tb_mem[mem_addr_o[5:2]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic we, input logic [31:0] a,
                         input logic [3:0] m, input logic [31:0] d);
    req_i[k]               = 1'b1;
    we_i[k]                = we;
    addr_i[k*ADDR_W +: ADDR_W] = a;
    wr_mask_i[k*MASK_W +: MASK_W] = m;
    wdata_i[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"},    64'(gnt_o),         64'h0);
    chk({tag, "_rvalid"}, 64'(rvalid_o),      64'h0);
    chk({tag, "_rdata"},  64'(rdata_o),       64'h0);
    chk({tag, "_maddr"},  64'(mem_addr_o),    64'h0);
    chk({tag, "_mwe"},    64'(mem_we_o),      64'h0);
    chk({tag, "_mmask"},  64'(mem_wr_mask_o), 64'h0);
    chk({tag, "_mdata"},  64'(mem_data_out_o),64'h0);
  endtask

  logic [1:0]  exp_g2;
  logic [31:0] exp_a2;
  logic [31:0] exp_d2;
  int          rv_count;

  initial begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_g2 = 2'b01; exp_a2 = 32'h10; exp_d2 = 32'hDEAD_BEEF;
`else
    exp_g2 = 2'b10; exp_a2 = 32'h20; exp_d2 = 32'hAAAA_1234;
`endif
    req_i = '0; we_i = '0; addr_i = '0; wr_mask_i = '0; wdata_i = '0;
    reset_i = 1'b1; tb_preload = 1'b1;
    tick(); tick();
    chk_quiet("reset");
    reset_i = 1'b0; tb_preload = 1'b0;
    tick();
    chk_quiet("post_reset");

    // 1: single read by requester 0.
    set_req(0, 1'b0, 32'h10, 4'h0, 32'h0);
    tick();
    chk("t1_gnt",   64'(gnt_o),      64'h1);
    chk("t1_maddr", 64'(mem_addr_o), 64'h10);
    chk("t1_mwe",   64'(mem_we_o),   64'h0);
    req_i[0] = 1'b0;
    tick();
    chk("t1_rvalid", 64'(rvalid_o),  64'h1);
    chk("t1_rdata",  64'(rdata_o),   64'hDEAD_BEEF);
    chk("t1_gnt_off",64'(gnt_o),     64'h0);
    chk("t1_maddr0", 64'(mem_addr_o),64'h0);
    tick();
    chk("t1_idle_rv", 64'(rvalid_o), 64'h0);

    // 2: masked write by requester 1 (low two bytes only).
    set_req(1, 1'b1, 32'h20, 4'b0011, 32'h0000_1234);
    tick();
    chk("t2_gnt",   64'(gnt_o),          64'h2);
    chk("t2_mwe",   64'(mem_we_o),       64'h1);
    chk("t2_mmask", 64'(mem_wr_mask_o),  64'h3);
    chk("t2_mdata", 64'(mem_data_out_o), 64'h1234);
    chk("t2_maddr", 64'(mem_addr_o),     64'h20);
    req_i[1] = 1'b0;
    tick();
    chk("t2_rvalid", 64'(rvalid_o), 64'h2);
    chk("t2_rdata",  64'(rdata_o),  64'h0);
    chk("t2_mwe_off",64'(mem_we_o), 64'h0);
    tick();

    // Read back the written word: upper bytes untouched.
    set_req(0, 1'b0, 32'h20, 4'h0, 32'h0);
    tick();
    chk("rb_gnt", 64'(gnt_o), 64'h1);
    req_i[0] = 1'b0;
    tick();
    chk("rb_rvalid", 64'(rvalid_o), 64'h1);
    chk("rb_rdata",  64'(rdata_o),  64'hAAAA_1234);
    tick();

    // 4: requester 1 drops req right after being registered; one completion.
    set_req(1, 1'b0, 32'h10, 4'h0, 32'h0);
    tick();
    chk("t4_gnt", 64'(gnt_o), 64'h2);
    req_i[1] = 1'b0;
    rv_count = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) chk("t4_rdata", 64'(rdata_o), 64'hDEAD_BEEF);
      if (rvalid_o == 2'b10) rv_count++;
    end
    chk("t4_rvalid_once", 64'(rv_count), 64'h1);

    // 5: reset arrives while in DATA after a requester-0 access.
    set_req(0, 1'b0, 32'h10, 4'h0, 32'h0);
    tick();
    chk("t5_gnt", 64'(gnt_o), 64'h1);
    req_i[0] = 1'b0;
    tick();
    chk("t5_rvalid", 64'(rvalid_o), 64'h1);
    reset_i = 1'b1;
    tick();
    chk_quiet("t5_reset");
    reset_i = 1'b0;
    tick();
    chk_quiet("t5_after");

    // 3: both requesters continuous; pointer restarts at 0 after reset.
    set_req(0, 1'b0, 32'h10, 4'h0, 32'h0);
    set_req(1, 1'b0, 32'h20, 4'h0, 32'h0);
    tick();
    chk("t3_g1",  64'(gnt_o),      64'h1);
    chk("t3_a1",  64'(mem_addr_o), 64'h10);
    tick();
    chk("t3_rv1", 64'(rvalid_o),   64'h1);
    chk("t3_d1",  64'(rdata_o),    64'hDEAD_BEEF);
    chk("t3_g1off", 64'(gnt_o),    64'h0);
    tick();
    chk("t3_g2",  64'(gnt_o),      64'(exp_g2));
    chk("t3_a2",  64'(mem_addr_o), 64'(exp_a2));
    chk("t3_rv2off", 64'(rvalid_o),64'h0);
    tick();
    chk("t3_rv2", 64'(rvalid_o),   64'(exp_g2));
    chk("t3_d2",  64'(rdata_o),    64'(exp_d2));
    tick();
    chk("t3_g3",  64'(gnt_o),      64'h1);
    tick();
    chk("t3_rv3", 64'(rvalid_o),   64'h1);
    // Single remaining requester is re-granted every two cycles.
    req_i[1] = 1'b0;
    tick();
    chk("t3_g4",  64'(gnt_o),      64'h1);
    tick();
    chk("t3_rv4", 64'(rvalid_o),   64'h1);
    req_i[0] = 1'b0;
    tick();
    chk("t3_end_gnt", 64'(gnt_o),    64'h0);
    chk("t3_end_rv",  64'(rvalid_o), 64'h0);

    // 6: ten idle cycles, everything stays at zero.
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_quiet("t6_idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_mem_arbiter
